// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath stages.
//   WIDTH_X / WIDTH_B / WIDTH_Y / WIDTH_O : default input, coefficient,
//                                           filter output and requantized widths
//   round_sat()                           : round-half-up arithmetic shift
//                                           followed by signed saturation
package fir_pkg;

  localparam int WIDTH_X = 8;
  localparam int WIDTH_B = 8;
  localparam int WIDTH_Y = 8;
  localparam int WIDTH_O = 4;

  // Works on a 32-bit signed container so one function serves every stage.
  // Callers sign-extend their sample into it, so WIDTH_Y must stay below 31
  // to leave headroom for the rounding add. With shift == 0 no rounding
  // term is added.
  function automatic logic signed [31:0] round_sat(input logic signed [31:0] v,
                                                   input int shift,
                                                   input int wo);
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    if (shift > 0) begin
      r = (v + (32'sd1 <<< (shift - 1))) >>> shift;
    end else begin
      r = v;
    end
    hi = (32'sd1 <<< (wo - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (wo - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rstn         : clock, asynchronous active-low reset
//   wr_en, wr_data    : write request; accepted when not full, or when full
//                       with a read happening in the same cycle
//   rd_en             : pop the head word (ignored when empty)
//   rd_data           : head word, forced to 0 while empty
//   full, empty, count: fill status
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  // Masking the head while empty keeps the output at 0 out of reset
  // without having to reset the storage array.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: requantize, decimate and buffer the filter output.
//   clk, rstn  : clock, asynchronous active-low reset
//   y_valid, y : signed FIR output sample and its qualifier
//   o_data     : signed requantized sample at the FIFO head (0 when empty)
//   o_valid    : FIFO non-empty
//   o_ready    : downstream accept; a transfer happens on o_valid && o_ready
//   count      : FIFO fill level
//   overflow   : sticky flag, set when a kept sample is dropped on a full FIFO
//   clr_ovf    : synchronous clear of overflow (a same-cycle drop wins)
module fir_out_decim
  import fir_pkg::*;
#(
  parameter int WIDTH_Y = fir_pkg::WIDTH_Y,
  parameter int WIDTH_O = fir_pkg::WIDTH_O,
  parameter int SHIFT   = 2,
  parameter int DECIM   = 2,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       y_valid,
  input  logic [WIDTH_Y-1:0]         y,
  output logic [WIDTH_O-1:0]         o_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0]        phase;
  logic                 keep;
  logic signed [31:0]   y_ext;
  logic signed [31:0]   r_full;
  logic                 unused_r_hi;
  logic                 pipe_vld;
  logic [WIDTH_O-1:0]   pipe_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 rd_en;
  logic                 drop;

  // The first valid sample after reset is kept because phase starts at 0.
  assign keep = y_valid && (phase == '0);

  assign y_ext  = {{(32 - WIDTH_Y){y[WIDTH_Y-1]}}, y};
  assign r_full = round_sat(y_ext, SHIFT, WIDTH_O);
  // After saturation the upper bits are pure sign extension.
  assign unused_r_hi = ^r_full[31:WIDTH_O];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= '0;
    end else if (y_valid) begin
      phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_vld  <= 1'b0;
      pipe_data <= '0;
    end else begin
      pipe_vld <= keep;
      if (keep) begin
        pipe_data <= r_full[WIDTH_O-1:0];
      end
    end
  end

  assign o_valid = !fifo_empty;
  assign rd_en   = o_valid && o_ready;
  assign drop    = pipe_vld && fifo_full && !rd_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH_O),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (pipe_vld),
    .wr_data (pipe_data),
    .rd_en   (rd_en),
    .rd_data (o_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

endmodule
